// File: rtl/friscv_pkg.sv
// Shared definitions for the fetch stage: opcode encodings, fetch FSM
// state type, NOP encoding and instruction length.
package friscv_pkg;

  localparam logic [6:0] OPC_REG       = 7'b0110011;
  localparam logic [6:0] OPC_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OPC_IMM_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JUMP      = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned INSTR_LEN = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    ERROR
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_imm_gen.sv
// imm_gen: combinational immediate extractor.
//   instr_i : 32-bit instruction word
//   imm_o   : 32-bit immediate, format chosen by instr_i[6:0]; 0 for
//             opcodes that carry no immediate
module imm_gen
  import friscv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (instr_i[6:0])
      OPC_IMM_ARITH, OPC_IMM_LOAD, OPC_JALR:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'b0};
      OPC_JUMP:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, fetches one word per
// instruction over a req/gnt/rvalid handshake and presents the decoded
// fields downstream with a valid/ready handshake.
//   clk_in, rst_in          : clock, synchronous active-high reset
//   fetch_en_in             : permits starting a new fetch
//   imem_req_out/addr_out   : memory request and address (= pc_out)
//   imem_gnt_in             : request accepted (honoured in REQ only)
//   imem_rvalid_in/rdata_in : read response (honoured in WAIT only)
//   instr_valid_out/ready_in: downstream handshake
//   pc_out, instr_out, op_code_out, func3_out, func7_out, rd_out,
//   rs1_out, rs2_out, imm_out : held instruction and its fields
//   pc_src_in/target_addr_in: next-PC select on accept (1 = PC+4)
//   err_out                 : sticky misaligned-redirect flag
module fetch_unit
  import friscv_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  fetch_en_in,
  output logic                  imem_req_out,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic                  imem_gnt_in,
  input  logic                  imem_rvalid_in,
  input  logic [31:0]           imem_rdata_in,
  output logic                  instr_valid_out,
  input  logic                  instr_ready_in,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [31:0]           instr_out,
  output logic [6:0]            op_code_out,
  output logic [2:0]            func3_out,
  output logic [6:0]            func7_out,
  output logic [4:0]            rd_out,
  output logic [4:0]            rs1_out,
  output logic [4:0]            rs2_out,
  output logic [31:0]           imm_out,
  input  logic                  pc_src_in,
  input  logic [ADDR_WIDTH-1:0] target_addr_in,
  output logic                  err_out
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic                  req_q, valid_q, err_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: if (fetch_en_in) state_d = REQ;
      REQ:  if (imem_gnt_in) state_d = WAIT;
      WAIT: if (imem_rvalid_in) begin
        instr_d = imem_rdata_in;
        state_d = HOLD;
      end
      HOLD: if (instr_ready_in) begin
        // A misaligned redirect leaves the PC at the faulting instruction.
        if (!pc_src_in && (target_addr_in[1:0] != 2'b00)) begin
          state_d = ERROR;
        end else begin
          pc_d    = pc_src_in ? pc_q + ADDR_WIDTH'(INSTR_LEN) : target_addr_in;
          state_d = fetch_en_in ? REQ : IDLE;
        end
      end
      ERROR: state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= (state_d == REQ);
      valid_q <= (state_d == HOLD);
      err_q   <= (state_d == ERROR);
    end
  end

  assign imem_req_out    = req_q;
  assign imem_addr_out   = pc_q;
  assign instr_valid_out = valid_q;
  assign err_out         = err_q;
  assign pc_out          = pc_q;
  assign instr_out       = instr_q;
  assign op_code_out     = instr_q[6:0];
  assign rd_out          = instr_q[11:7];
  assign func3_out       = instr_q[14:12];
  assign rs1_out         = instr_q[19:15];
  assign rs2_out         = instr_q[24:20];
  assign func7_out       = instr_q[31:25];

  imm_gen u_imm_gen (
    .instr_i (instr_q),
    .imm_o   (imm_out)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of instructions with expected
// immediates, scoreboard queue filled on rvalid and drained on valid, plus
// hand sequences for redirect, misalignment, reset and PC wrap.
module tb_fetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        fetch_en_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [6:0]  op_code_out;
  logic [2:0]  func3_out;
  logic [6:0]  func7_out;
  logic [4:0]  rd_out, rs1_out, rs2_out;
  logic [31:0] imm_out;
  logic        pc_src_in;
  logic [31:0] target_addr_in;
  logic        err_out;

  always #5 clk_in = ~clk_in;

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .fetch_en_in     (fetch_en_in),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_gnt_in     (imem_gnt_in),
    .imem_rvalid_in  (imem_rvalid_in),
    .imem_rdata_in   (imem_rdata_in),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in),
    .pc_out          (pc_out),
    .instr_out       (instr_out),
    .op_code_out     (op_code_out),
    .func3_out       (func3_out),
    .func7_out       (func7_out),
    .rd_out          (rd_out),
    .rs1_out         (rs1_out),
    .rs2_out         (rs2_out),
    .imm_out         (imm_out),
    .pc_src_in       (pc_src_in),
    .target_addr_in  (target_addr_in),
    .err_out         (err_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    int unsigned gnt_dly;
    int unsigned rv_dly;
    int unsigned rdy_dly;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] imm;
  } exp_t;

  localparam int unsigned NVEC = 12;
  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  int unsigned vec_cnt  = 0;
  int unsigned miss_cnt = 0;
  logic [31:0] exp_pc;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // One complete fetch: wait for req, grant, return data, hold, accept.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                          input logic [31:0] exp_imm, input int unsigned gnt_dly,
                          input int unsigned rv_dly, input int unsigned rdy_dly,
                          input logic src, input logic [31:0] tgt, input logic fen_after);
    exp_t        e;
    int unsigned k;
    k = 0;
    while (!imem_req_out && k < 20) begin
      step();
      k++;
    end
    chk1("req_seen", imem_req_out, 1'b1);
    if (!imem_req_out) return;
    chk("req_addr", imem_addr_out, exp_addr);
    chk("pc_at_req", pc_out, exp_addr);
    for (int unsigned i = 0; i < gnt_dly; i++) begin
      step();
      chk1("req_hold", imem_req_out, 1'b1);
      chk("addr_hold", imem_addr_out, exp_addr);
    end
    imem_gnt_in = 1'b1;
    step();
    imem_gnt_in = 1'b0;
    chk1("req_drop", imem_req_out, 1'b0);
    chk1("valid_wait", instr_valid_out, 1'b0);
    for (int unsigned i = 0; i < rv_dly; i++) begin
      step();
      chk1("valid_early", instr_valid_out, 1'b0);
      chk1("req_in_wait", imem_req_out, 1'b0);
    end
    imem_rvalid_in = 1'b1;
    imem_rdata_in  = data;
    sb_q.push_back('{exp_addr, data, exp_imm});
    step();
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = 32'hDEAD_BEEF;
    chk1("valid", instr_valid_out, 1'b1);
    if (instr_valid_out && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      for (int unsigned i = 0; i <= rdy_dly; i++) begin
        if (i != 0) step();
        chk1("valid_hold", instr_valid_out, 1'b1);
        chk("pc", pc_out, e.addr);
        chk("instr", instr_out, e.instr);
        chk("imm", imm_out, e.imm);
        chk("op_code", {25'b0, op_code_out}, {25'b0, e.instr[6:0]});
        chk("rd", {27'b0, rd_out}, {27'b0, e.instr[11:7]});
        chk("func3", {29'b0, func3_out}, {29'b0, e.instr[14:12]});
        chk("rs1", {27'b0, rs1_out}, {27'b0, e.instr[19:15]});
        chk("rs2", {27'b0, rs2_out}, {27'b0, e.instr[24:20]});
        chk("func7", {25'b0, func7_out}, {25'b0, e.instr[31:25]});
      end
    end
    instr_ready_in = 1'b1;
    pc_src_in      = src;
    target_addr_in = tgt;
    fetch_en_in    = fen_after;
    step();
    instr_ready_in = 1'b0;
    pc_src_in      = 1'b1;
    chk1("valid_drop", instr_valid_out, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h0050_0093, 32'h0000_0005, 0, 0, 0};  // addi x1,x0,5
    vecs[1]  = '{32'hFE11_2E23, 32'hFFFF_FFFC, 3, 2, 4};  // store
    vecs[2]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 0, 0, 0};  // branch, instr[7]=1
    vecs[3]  = '{32'hFE00_0E63, 32'hFFFF_F7FC, 1, 0, 2};  // branch, instr[7]=0
    vecs[4]  = '{32'h1234_52B7, 32'h1234_5000, 0, 1, 0};  // lui
    vecs[5]  = '{32'h0040_00EF, 32'h0000_0004, 2, 0, 1};  // jal +4
    vecs[6]  = '{32'hFFDF_F0EF, 32'hFFFF_FFFC, 0, 3, 0};  // jal -4
    vecs[7]  = '{32'h0000_8067, 32'h0000_0000, 0, 0, 3};  // jalr
    vecs[8]  = '{32'hFFFF_F517, 32'hFFFF_F000, 1, 1, 1};  // auipc
    vecs[9]  = '{32'h0020_81B3, 32'h0000_0000, 0, 0, 0};  // add (no imm)
    vecs[10] = '{32'h8000_A103, 32'hFFFF_F800, 0, 2, 0};  // lw -2048
    vecs[11] = '{32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 0};  // unknown opcode

    rst_in = 1'b1; fetch_en_in = 1'b0; imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0;
    imem_rdata_in = '0; instr_ready_in = 1'b0; pc_src_in = 1'b1; target_addr_in = '0;
    step();
    step();
    rst_in = 1'b0;
    chk1("rst_req", imem_req_out, 1'b0);
    chk1("rst_valid", instr_valid_out, 1'b0);
    chk1("rst_err", err_out, 1'b0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0000_0013);

    // Sequential run through the table, ready/latency variations per entry.
    fetch_en_in = 1'b1;
    exp_pc = 32'h0;
    for (int unsigned i = 0; i < NVEC; i++) begin
      do_fetch(exp_pc, vecs[i].instr, vecs[i].imm, vecs[i].gnt_dly,
               vecs[i].rv_dly, vecs[i].rdy_dly, 1'b1, 32'h0, 1'b1);
      exp_pc = exp_pc + 32'd4;
    end

    // Redirect to an aligned target, then stop in IDLE.
    do_fetch(exp_pc, 32'h0000_0013, 32'h0, 0, 0, 0, 1'b0, 32'h100, 1'b1);
    do_fetch(32'h100, 32'h0050_0093, 32'h5, 0, 0, 0, 1'b1, 32'h0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      if (i == 1) begin
        imem_gnt_in = 1'b1;   // stray gnt/rvalid while idle
        imem_rvalid_in = 1'b1;
        imem_rdata_in = 32'h1234_52B7;
      end
      step();
      imem_gnt_in = 1'b0;
      imem_rvalid_in = 1'b0;
      chk1("idle_req", imem_req_out, 1'b0);
      chk1("idle_valid", instr_valid_out, 1'b0);
      chk("idle_pc", pc_out, 32'h104);
      chk("idle_instr", instr_out, 32'h0050_0093);
    end

    // Misaligned redirect.
    fetch_en_in = 1'b1;
    do_fetch(32'h104, 32'h0000_0013, 32'h0, 0, 0, 0, 1'b0, 32'h102, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      chk1("err_set", err_out, 1'b1);
      chk1("err_req", imem_req_out, 1'b0);
      chk1("err_valid", instr_valid_out, 1'b0);
      chk("err_pc", pc_out, 32'h104);
      step();
    end
    fetch_en_in = 1'b0;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk1("err_clear", err_out, 1'b0);
    chk("err_rst_pc", pc_out, 32'h0);

    // Reset while waiting for rvalid; rvalid in the same cycle is lost.
    fetch_en_in = 1'b1;
    step();
    chk1("mid_req", imem_req_out, 1'b1);
    imem_gnt_in = 1'b1;
    fetch_en_in = 1'b0;
    step();
    imem_gnt_in = 1'b0;
    rst_in = 1'b1;
    imem_rvalid_in = 1'b1;
    imem_rdata_in = 32'h0050_0093;
    step();
    rst_in = 1'b0;
    imem_rvalid_in = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      chk1("midrst_valid", instr_valid_out, 1'b0);
      chk1("midrst_req", imem_req_out, 1'b0);
      chk("midrst_pc", pc_out, 32'h0);
      chk("midrst_instr", instr_out, 32'h0000_0013);
      step();
    end

    // PC wrap at the top of the address space.
    fetch_en_in = 1'b1;
    do_fetch(32'h0, 32'h0000_0013, 32'h0, 0, 0, 0, 1'b0, 32'hFFFF_FFFC, 1'b1);
    do_fetch(32'hFFFF_FFFC, 32'h0000_8067, 32'h0, 0, 0, 0, 1'b1, 32'h0, 1'b1);
    do_fetch(32'h0, 32'h1234_52B7, 32'h1234_5000, 0, 0, 0, 1'b1, 32'h0, 1'b0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
